// File: rtl/load_store_unit.sv
// load_store_unit
// Bridges the execute stage to a single-ported data memory for RISC-V
// loads and stores. A legal access is accepted in IDLE. It is issued to
// memory from BUSY until mem_ready is seen or the wait budget runs out.
// The access then retires with a one-cycle done pulse in DONE.
//
// Ports
//   Clock, Reset           rising-edge clock, synchronous active-high reset
//   valid                  execute stage presents an instruction
//   is_load, is_store      instruction class from the decoder
//   funct3                 RISC-V load/store width/sign field
//   addr                   effective address (ALU result)
//   store_data             rs2 value for stores
//   stall                  holds the upstream stage while an access is in flight
//   done                   one-cycle completion pulse
//   load_data              extended load result, non-zero only while done=1
//   fault                  one-cycle pulse: misaligned, illegal or timed out
//   mem_req, mem_we        memory request strobe and write enable
//   mem_addr               word-aligned memory address
//   mem_wdata, mem_wmask   lane-replicated write data and byte enables
//   mem_ready, mem_rdata   access-complete strobe and read data
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // Counter holds 0 .. TIMEOUT_CYCLES-1, one value per BUSY cycle.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [29:0] word_addr_r;
    logic [1:0]  off_r;
    logic [2:0]  funct3_r;
    logic        we_r;
    logic [31:0] wdata_r;
    logic [3:0]  wmask_r;
    logic [31:0] rdata_r;
    logic        timed_out_r;
    logic [CNT_W-1:0] cnt;

    logic        mem_op;
    logic        f3_legal;
    logic        misaligned;
    logic        bad_op;
    logic        accept;
    logic [31:0] wdata_n;
    logic [3:0]  wmask_n;

    assign mem_op = valid & (is_load | is_store);

    always_comb begin
        f3_legal = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end
    end

    // funct3[1:0] encodes the access size for every legal opcode.
    assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                        ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

    assign bad_op = (is_load & is_store) | ~f3_legal | misaligned;
    assign accept = (state == IDLE) & mem_op & ~bad_op;

    // Store lane formatting: data is replicated so the mask alone selects lanes.
    always_comb begin
        wdata_n = '0;
        wmask_n = '0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata_n = {4{store_data[7:0]}};
                    wmask_n = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    wdata_n = {2{store_data[15:0]}};
                    wmask_n = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_n = store_data;
                    wmask_n = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            word_addr_r <= '0;
            off_r       <= '0;
            funct3_r    <= '0;
            we_r        <= 1'b0;
            wdata_r     <= '0;
            wmask_r     <= '0;
            rdata_r     <= '0;
            timed_out_r <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_addr_r <= addr[31:2];
                        off_r       <= addr[1:0];
                        funct3_r    <= funct3;
                        we_r        <= is_store;
                        wdata_r     <= wdata_n;
                        wmask_r     <= wmask_n;
                        rdata_r     <= '0;
                        timed_out_r <= 1'b0;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // A response in the last budgeted cycle still wins over the timeout.
                    if (mem_ready) begin
                        rdata_r <= mem_rdata;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        timed_out_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs are gated by BUSY so they read zero at all other times.
    always_comb begin
        stall     = accept | (state == BUSY);
        done      = (state == DONE);
        fault     = ((state == IDLE) & mem_op & bad_op) | ((state == DONE) & timed_out_r);
        mem_req   = (state == BUSY);
        mem_we    = (state == BUSY) & we_r;
        mem_addr  = (state == BUSY) ? {word_addr_r, 2'b00} : '0;
        mem_wdata = (state == BUSY) ? wdata_r : '0;
        mem_wmask = (state == BUSY) ? wmask_r : '0;
    end

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b    = '0;
        lane_h    = '0;
        load_data = '0;
        case (off_r)
            2'b00:   lane_b = rdata_r[7:0];
            2'b01:   lane_b = rdata_r[15:8];
            2'b10:   lane_b = rdata_r[23:16];
            default: lane_b = rdata_r[31:24];
        endcase
        lane_h = off_r[1] ? rdata_r[31:16] : rdata_r[15:0];
        if ((state == DONE) & ~we_r & ~timed_out_r) begin
            case (funct3_r)
                3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
                3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
                3'b010:  load_data = rdata_r;
                3'b100:  load_data = {24'h0, lane_b};
                3'b101:  load_data = {16'h0, lane_h};
                default: load_data = '0;
            endcase
        end
    end

endmodule
